cntr_sequencer: RTL and testbench

//   Synchronous controller that sequences a WIDTH-bit counter through one programmed run.
//   It loads a start value, counts up to a limit or down to zero, then signals terminal count.

---
 rtl/cntr_sequencer.sv | 126 ++++++++++++
 tb/tb_cntr_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cntr_sequencer.sv
// Run sequencer for a WIDTH-bit counter: loads a clamped start value, counts up to a
// limit or down to zero, and flags terminal count in one-shot or auto-reload modes.
module cntr_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             mode_up,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             mode_up_q, mode_up_d;
  logic             auto_reload_q, auto_reload_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] reload_q, reload_d;

  logic             terminal;
  logic [WIDTH-1:0] load_clamped;

  // Terminal is judged against the shadowed run settings, never the live inputs.
  assign terminal     = mode_up_q ? (q_q == limit_q) : (q_q == '0);
  assign load_clamped = (load_val > limit) ? limit : load_val;

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q       <= ST_IDLE;
      q_q           <= '0;
      busy_q        <= 1'b0;
      tc_q          <= 1'b0;
      done_q        <= 1'b0;
      mode_up_q     <= 1'b0;
      auto_reload_q <= 1'b0;
      limit_q       <= '0;
      reload_q      <= '0;
    end else begin
      state_q       <= state_d;
      q_q           <= q_d;
      busy_q        <= busy_d;
      tc_q          <= tc_d;
      done_q        <= done_d;
      mode_up_q     <= mode_up_d;
      auto_reload_q <= auto_reload_d;
      limit_q       <= limit_d;
      reload_q      <= reload_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop)          state_d = ST_IDLE;
        else if (terminal) state_d = auto_reload_q ? ST_RUN : ST_IDLE;
        else if (hold)     state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop)       state_d = ST_IDLE;
        else if (!hold) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    q_d           = q_q;
    tc_d          = 1'b0;
    done_d        = 1'b0;
    mode_up_d     = mode_up_q;
    auto_reload_d = auto_reload_q;
    limit_d       = limit_q;
    reload_d      = reload_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          mode_up_d     = mode_up;
          auto_reload_d = auto_reload;
          limit_d       = limit;
          reload_d      = load_clamped;
          q_d           = load_clamped;
        end
      end
      ST_RUN: begin
        if (!stop) begin
          if (terminal) begin
            tc_d = 1'b1;
            if (auto_reload_q) q_d = reload_q;
            else               done_d = 1'b1;
          end else if (!hold) begin
            q_d = mode_up_q ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign q    = q_q;
  assign busy = busy_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule

// File: tb/tb_cntr_sequencer.sv
// Directed bench for cntr_sequencer: hand-computed q/busy/tc/done after every edge.
module tb_cntr_sequencer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             clear;
  logic             start;
  logic             stop;
  logic             hold;
  logic             mode_up;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;
  logic             done;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_no      = 0;

  always #5 clk = ~clk;

  cntr_sequencer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .stop        (stop),
    .hold        (hold),
    .mode_up     (mode_up),
    .auto_reload (auto_reload),
    .load_val    (load_val),
    .limit       (limit),
    .q           (q),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s edge=%0d got=%0d expected=%0d", tag, edge_no, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic expect_out(input string tag, input int eq, input int eb, input int et, input int ed);
    check({tag, ".q"},    32'(q),    eq);
    check({tag, ".busy"}, 32'(busy), eb);
    check({tag, ".tc"},   32'(tc),   et);
    check({tag, ".done"}, 32'(done), ed);
    $display("[TB] %s edge=%0d q=%0d busy=%0b tc=%0b done=%0b", tag, edge_no, q, busy, tc, done);
  endtask

  task automatic launch(input int lv, input int lim, input logic up, input logic ar);
    load_val    = WIDTH'(lv);
    limit       = WIDTH'(lim);
    mode_up     = up;
    auto_reload = ar;
    start       = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
    mode_up = 1'b1; auto_reload = 1'b0; load_val = '0; limit = '0;
    tick(); tick();
    expect_out("reset", 0, 0, 0, 0);
    clear = 1'b1;

    // 1: up one-shot, load 3 limit 9; live inputs and start changed mid-run
    launch(3, 9, 1'b1, 1'b0);
    expect_out("t1.start", 3, 1, 0, 0);
    limit = 4'd4; load_val = 4'd7; mode_up = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      start = (i == 3);
      tick();
      start = 1'b0;
      expect_out("t1.count", 3 + i, 1, 0, 0);
    end
    tick();
    expect_out("t1.term", 9, 0, 1, 1);
    tick();
    expect_out("t1.idle", 9, 0, 0, 0);

    // 2: down auto-reload, load 2
    launch(2, 9, 1'b0, 1'b1);
    expect_out("t2.start", 2, 1, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      expect_out("t2.run", (i % 3 == 0) ? 2 : 2 - (i % 3), 1, (i % 3 == 0) ? 1 : 0, 0);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    expect_out("t2.stop", 2, 0, 0, 0);

    // 3: up one-shot load 0 limit 5, hold for 3 edges at q=2
    launch(0, 5, 1'b1, 1'b0);
    expect_out("t3.start", 0, 1, 0, 0);
    tick(); expect_out("t3.c1", 1, 1, 0, 0);
    tick(); expect_out("t3.c2", 2, 1, 0, 0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("t3.pause", 2, 1, 0, 0);
    end
    hold = 1'b0;
    tick(); expect_out("t3.resume", 2, 1, 0, 0);
    tick(); expect_out("t3.c3", 3, 1, 0, 0);
    tick(); expect_out("t3.c4", 4, 1, 0, 0);
    tick(); expect_out("t3.c5", 5, 1, 0, 0);
    hold = 1'b1;
    tick(); expect_out("t3.term_hold", 5, 0, 1, 1);
    hold = 1'b0;

    // 4: stop at q=6, then restart
    launch(0, 9, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) tick();
    expect_out("t4.q6", 6, 1, 0, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    expect_out("t4.stop", 6, 0, 0, 0);
    tick(); expect_out("t4.idle", 6, 0, 0, 0);
    launch(1, 9, 1'b1, 1'b0);
    expect_out("t4.restart", 1, 1, 0, 0);
    tick(); expect_out("t4.count", 2, 1, 0, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    expect_out("t4.stop2", 2, 0, 0, 0);

    // 5: load above limit clamps
    launch(12, 9, 1'b1, 1'b0);
    expect_out("t5.clamp", 9, 1, 0, 0);
    tick(); expect_out("t5.term", 9, 0, 1, 1);

    // limit 0 in up mode: terminal on the first RUN edge
    launch(5, 0, 1'b1, 1'b0);
    expect_out("lim0.start", 0, 1, 0, 0);
    tick(); expect_out("lim0.term", 0, 0, 1, 1);

    // reload equal to terminal: tc on every RUN edge
    launch(0, 9, 1'b0, 1'b1);
    expect_out("rl0.start", 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("rl0.run", 0, 1, 1, 0);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    expect_out("rl0.stop", 0, 0, 0, 0);

    // 6: clear mid-run at q=4, start ignored while clear low and with stop high
    launch(0, 9, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) tick();
    expect_out("t6.q4", 4, 1, 0, 0);
    clear = 1'b0; start = 1'b1; load_val = 4'd3;
    tick();
    expect_out("t6.clear", 0, 0, 0, 0);
    clear = 1'b1; stop = 1'b1;
    tick();
    expect_out("t6.start_stop", 0, 0, 0, 0);
    start = 1'b0; stop = 1'b0;
    tick();
    expect_out("t6.idle", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
